// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache memory arbiter: RAM word, RAM handshake state
// and the arbiter FSM encoding.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cycles the icache has been kept waiting.
// Clear beats increment; sat is high once the count reaches LIMIT.
module arb_starve_ctr #(
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign sat = (count == W'(LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !sat)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fills and dcache reads/writes.
// Dcache has priority unless the icache has starved for STARVE_LIMIT cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    arb_state_t state, next_state;
    logic       d_req;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;
    logic       granted;

    assign d_req   = dREN | dWEN;
    assign granted = (state == IGNT) || (state == DGNT);

    // Counting stops while the icache holds the grant; a dropped request or a
    // fresh icache grant restarts the starvation window.
    assign starve_inc = iREN && (state != IGNT);
    assign starve_clr = !iREN || ((state != IGNT) && (next_state == IGNT));

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (starve_inc),
        .clr  (starve_clr),
        .sat  (starve_sat)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ram_err <= 1'b0;
        else if (granted && (ramstate == ERROR))
            ram_err <= 1'b1;
    end

    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state)
            IDLE: begin
                if (starve_sat && iREN)
                    next_state = IGNT;
                else if (d_req)
                    next_state = DGNT;
                else if (iREN)
                    next_state = IGNT;
            end

            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                // A flush aborts even if the RAM finishes this cycle; the fill is discarded.
                if (!iREN)
                    next_state = IDLE;
                else if (ramstate == ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end

            DGNT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req)
                    next_state = IDLE;
                else if (ramstate == ACCESS) begin
                    dwait      = 1'b0;
                    dload      = dWEN ? '0 : ramload;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a scripted RAM model plus an in-order queue of
// expected completions checked whenever iwait or dwait drops.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        logic  is_i;
        word_t data;
    } exp_t;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, ram_err;
    ramstate_t ramstate;

    int   checks = 0;
    int   failures = 0;
    int   n_err = 0;
    int   n_busy = 0;
    int   acc;
    exp_t sb[$];

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    always #5 CLK = ~CLK;

    function automatic word_t data_of(input word_t a);
        return (a == 32'h40) ? 32'h8C01_0004 : {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: n_err ERROR cycles, then n_busy BUSY cycles, then ACCESS.
    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN) begin
            if (acc < n_err)               ramstate = ERROR;
            else if (acc < n_err + n_busy) ramstate = BUSY;
            else                           ramstate = ACCESS;
        end
    end

    always_comb ramload = data_of(ramaddr);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)
            acc <= 0;
        else if ((ramREN || ramWEN) && (ramstate != ACCESS))
            acc <= acc + 1;
        else
            acc <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input logic is_i, input word_t got);
        exp_t e;
        if (sb.size() == 0) begin
            chk(is_i ? "i_unexpected" : "d_unexpected", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk(is_i ? "i_src" : "d_src", 32'(is_i), 32'(e.is_i));
        chk(is_i ? "iload" : "dload", got, e.data);
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (iwait === 1'b0) sb_pop(1'b1, iload);
            if (dwait === 1'b0) sb_pop(1'b0, dload);
        end
    end

    task automatic clear_req();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
    endtask

    // Wait for one completion, checking the held RAM request on every grant cycle.
    task automatic run_xfer(input logic is_i, input int exp_lat, input logic exp_wen,
                            input word_t exp_addr, input word_t exp_store);
        int c;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < 64) begin
            @(negedge CLK);
            c++;
            if (c >= 2) begin
                chk("strobes", {30'b0, ramREN, ramWEN}, exp_wen ? 32'd1 : 32'd2);
                chk("ramaddr", ramaddr, exp_addr);
                chk("ramstore", ramstore, exp_store);
            end
            if (is_i ? (iwait === 1'b0) : (dwait === 1'b0)) done = 1;
        end
        chk("latency", 32'(c), 32'(exp_lat));
        @(posedge CLK); #1;
        clear_req();
        @(negedge CLK);
        chk("idle_after", {29'b0, ramREN, ramWEN, 1'(dut.state != IDLE)}, 32'd0);
    endtask

    initial begin
        int  nd;
        bit  done;
        exp_t e;

        nRST = 1'b1;
        clear_req();
        #2 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ram_err", 32'(ram_err), 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;

        // icache fill with two BUSY cycles
        @(posedge CLK); #1;
        n_err = 0; n_busy = 2;
        iREN = 1; iaddr = 32'h40;
        e.is_i = 1; e.data = 32'h8C01_0004; sb.push_back(e);
        run_xfer(1'b1, 4, 1'b0, 32'h40, 32'h0);

        // dcache write with one BUSY cycle
        @(posedge CLK); #1;
        n_err = 0; n_busy = 1;
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        e.is_i = 0; e.data = 32'h0; sb.push_back(e);
        run_xfer(1'b0, 3, 1'b1, 32'h100, 32'hDEAD_BEEF);

        // starvation: four dcache reads, then the icache takes over
        @(posedge CLK); #1;
        n_err = 0; n_busy = 0;
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            e.is_i = 0; e.data = data_of(32'h200); sb.push_back(e);
        end
        e.is_i = 1; e.data = data_of(32'h80); sb.push_back(e);
        nd = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (dwait === 1'b0) nd++;
            if (iwait === 1'b0) begin
                chk("starve_ctr_ignt", 32'(dut.u_starve.count), 32'd0);
                chk("d_before_i", 32'(nd), 32'd4);
                done = 1;
            end
        end
        chk("starve_done", 32'(done), 32'd1);
        @(posedge CLK); #1 clear_req();
        @(negedge CLK);
        chk("starve_idle", {30'b0, ramREN, ramWEN}, 32'd0);

        // ERROR x3 during a dcache read, then ACCESS
        chk("err_before", 32'(ram_err), 32'd0);
        @(posedge CLK); #1;
        n_err = 3; n_busy = 0;
        dREN = 1; daddr = 32'h300;
        e.is_i = 0; e.data = data_of(32'h300); sb.push_back(e);
        run_xfer(1'b0, 5, 1'b0, 32'h300, 32'h0);
        chk("err_sticky", 32'(ram_err), 32'd1);

        // icache flush in second IGNT cycle
        @(posedge CLK); #1;
        n_err = 0; n_busy = 5;
        iREN = 1; iaddr = 32'h500;
        @(posedge CLK);
        @(posedge CLK); #1 iREN = 0;
        @(negedge CLK);
        chk("abort_ren_held", 32'(ramREN), 32'd1);
        chk("abort_iwait", 32'(iwait), 32'd1);
        @(negedge CLK);
        chk("abort_ren_drop", 32'(ramREN), 32'd0);
        chk("abort_iwait2", 32'(iwait), 32'd1);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("err_sticky2", 32'(ram_err), 32'd1);

        // async reset during a write grant
        @(posedge CLK); #1;
        n_err = 0; n_busy = 10;
        dWEN = 1; daddr = 32'h600; dstore = 32'h1234_5678;
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_rst_wen", 32'(ramWEN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_wen_drop", 32'(ramWEN), 32'd0);
        chk("rst_dwait", 32'(dwait), 32'd1);
        clear_req();
        @(posedge CLK); @(posedge CLK); #1 nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));
        chk("post_rst_ctr", 32'(dut.u_starve.count), 32'd0);
        chk("post_rst_err", 32'(ram_err), 32'd0);

        repeat (2) @(negedge CLK);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
